s2p_arbiter: RTL
================

# s2p_arbiter

Round-robin controller that shares one serial-to-parallel deserializer engine among NREQ serial requesters. It grants one requester at a time, routes that requester's serial line into the engine, and issues the engine start pulse. It then waits for the engine's done pulse and returns the deserialized word, tagged with the requester index, over a valid/ready response channel. A timeout guard keeps a stalled engine from locking out every requester.

## Interface
- NREQ, 4, number of requesters (2..16)
- IDW, 2, requester-index width, must be ≥ clog2(NREQ)
- DW, 22, deserialized word width (matches the engine)
- TMO, 63, maximum BUSY cycles before timeout (1..2^TW-1)
- TW, 6, timeout-counter width
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  NREQ  level request per requester
- sdin  in  NREQ  serial data per requester, MSB first, one bit/clk while granted
- gnt  out  NREQ  one-hot grant, held for the whole transaction
- eng_start  out  1  one-cycle start pulse to the engine
- eng_sdin  out  1  serial bit muxed from the granted requester
- eng_dout  in  DW  engine parallel output
- eng_done  in  1  engine completion pulse
- rsp_valid  out  1  response word available
- rsp_ready  in  1  consumer accepts the response
- rsp_data  out  DW  captured word
- rsp_id  out  IDW  index of the requester that owns rsp_data
- rsp_err  out  1  response is a timeout error; rsp_data = 0

## Operation
- States: IDLE, GRANT, BUSY, RESP, DRAIN.
- IDLE:
  - If any req bit is set, choose the winner round-robin, searching upward from ptr+1 modulo NREQ.
  - Register gnt as one-hot of the winner, latch the winner into rsp_id, set ptr = winner, go to GRANT.
- GRANT: eng_start=1 for exactly this cycle; clear the timeout counter; go to BUSY.
- BUSY: the timeout counter increments each cycle.
  - eng_done=1: rsp_data ← eng_dout, rsp_err ← 0, gnt ← 0, go to RESP.
  - Otherwise, counter == TMO: rsp_data ← 0, rsp_err ← 1, gnt ← 0, go to DRAIN.
- RESP:
  - rsp_valid=1 and rsp_data, rsp_id, rsp_err are held stable.
  - rsp_valid && rsp_ready: go to IDLE and drop rsp_valid.
- DRAIN:
  - rsp_valid=1 with rsp_err=1. Leave only after both events occur: the handshake completes, and eng_done has been seen (eng_done may arrive first).
  - Then go to IDLE. The late engine word is discarded.
- eng_sdin = sdin[rsp_id] whenever gnt ≠ 0, else 0.
- req changes after the grant are ignored. Dropping req mid-transaction does not abort it.
- eng_done outside BUSY/DRAIN is ignored.
- Reset values:
  - State IDLE, ptr = NREQ-1 (so requester 0 wins first).
  - gnt=0, eng_start=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, counter=0.
- Reset is synchronous and overrides any state, including mid-BUSY. The engine is reset by the same rst.

## Timing
- req sampled in IDLE at edge N: gnt and eng_start are high in cycle N+1. gnt stays high from N+1 until the cycle eng_done is sampled.
- eng_sdin is combinational from sdin while gnt is set. The requester starts shifting its MSB in the first cycle it sees gnt.
- eng_done sampled at edge M: rsp_valid is high from M+1. Zero-wait consumer: IDLE at M+2, next grant visible at M+3.
- Grant-to-grant minimum is engine latency + 3 cycles.
- Timeout fires when the counter reaches TMO with no eng_done: rsp_valid/rsp_err high on the next cycle.
- eng_done and timeout in the same cycle: eng_done wins, giving a normal response.
- rsp_valid never drops without a handshake. There is no combinational path from rsp_ready to rsp_valid.

## Test plan
Parameters: NREQ=4, DW=22, TMO=63; the engine model asserts done 23 cycles after start.
- Single requester: req=4'b0100, sdin[2] shifts 22'h2A5A5A → gnt=4'b0100 and one eng_start pulse; after done, rsp_valid with rsp_data=22'h2A5A5A, rsp_id=2, rsp_err=0.
- Fairness: req=4'b1111 held for 8 transactions → grant order 0,1,2,3,0,1,2,3 after reset; each transaction has exactly one eng_start.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid → rsp_data/rsp_id stable; no new gnt until the handshake; IDLE on the cycle after rsp_ready=1.
- Timeout: engine never asserts done → rsp_err=1, rsp_data=0 once 63 BUSY cycles elapse. A late eng_done 100 cycles after start, following the handshake, returns the block to IDLE with no second response.
- Simultaneous events: eng_done on the same cycle the counter reaches 63 → rsp_err=0 and the engine data is returned.
- Reset mid-BUSY: assert rst 5 cycles into BUSY → next cycle gnt=0, rsp_valid=0, rsp_data=0, ptr=3. With req=4'b1111, the next grant goes to requester 0.

Source files
------------

// File: rtl/s2p_arbiter.sv
// Round-robin arbiter sharing one serial-to-parallel engine among NREQ requesters.
// Returns the engine word tagged with the requester id; a timeout reports an error response.
module s2p_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2,
    parameter int unsigned DW   = 22,
    parameter int unsigned TMO  = 63,
    parameter int unsigned TW   = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] sdin,
    output logic [NREQ-1:0] gnt,
    output logic            eng_start,
    output logic            eng_sdin,
    input  logic [DW-1:0]   eng_dout,
    input  logic            eng_done,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_data,
    output logic [IDW-1:0]  rsp_id,
    output logic            rsp_err
);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        BUSY,
        RESP,
        DRAIN
    } state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            eng_start_q, eng_start_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic            rsp_err_q, rsp_err_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic            done_seen_q, done_seen_d;

    logic            win_found;
    logic [IDW-1:0]  win_idx;
    logic            hs;

    // Round-robin pick: first requester above ptr, then wrap to those at or below it.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!win_found && req[i] && (IDW'(i) > ptr_q)) begin
                win_found = 1'b1;
                win_idx   = IDW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!win_found && req[i] && (IDW'(i) <= ptr_q)) begin
                win_found = 1'b1;
                win_idx   = IDW'(i);
            end
        end
    end

    assign hs = rsp_valid_q && rsp_ready;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        eng_start_d = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rsp_err_d   = rsp_err_q;
        cnt_d       = cnt_q;
        done_seen_d = done_seen_q;

        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    gnt_d       = NREQ'(1) << win_idx;
                    rsp_id_d    = win_idx;
                    ptr_d       = win_idx;
                    eng_start_d = 1'b1;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                cnt_d   = '0;
                state_d = BUSY;
            end
            BUSY: begin
                // A done in the timeout cycle still wins over the timeout.
                if (eng_done) begin
                    rsp_data_d  = eng_dout;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    gnt_d       = '0;
                    state_d     = RESP;
                end else if (cnt_q == TW'(TMO)) begin
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    gnt_d       = '0;
                    done_seen_d = 1'b0;
                    state_d     = DRAIN;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            RESP: begin
                if (hs) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            DRAIN: begin
                // Wait for both the handshake and the late engine done, in either order.
                if (hs) begin
                    rsp_valid_d = 1'b0;
                end
                if (eng_done) begin
                    done_seen_d = 1'b1;
                end
                if ((done_seen_q || eng_done) && (!rsp_valid_q || hs)) begin
                    done_seen_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= IDW'(NREQ - 1);
            gnt_q       <= '0;
            eng_start_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
            done_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            eng_start_q <= eng_start_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
            cnt_q       <= cnt_d;
            done_seen_q <= done_seen_d;
        end
    end

    assign gnt       = gnt_q;
    assign eng_start = eng_start_q;
    assign eng_sdin  = (gnt_q != '0) ? sdin[rsp_id_q] : 1'b0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;

endmodule
